// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter in front of a UART TX FIFO write port.
// A granted requester owns the port until its 'last' byte or a req-low timeout.
module uart_tx_arbiter #(
  parameter int N       = 2,
  parameter int B       = 8,
  parameter int TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*B-1:0] data,
  input  logic [N-1:0]   last,
  output logic [N-1:0]   ack,
  output logic [N-1:0]   gnt,
  input  logic           fifo_full,
  output logic           fifo_wr,
  output logic [B-1:0]   fifo_w_data,
  output logic           busy,
  output logic           abort
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [PW-1:0] LAST_IDX  = PW'(N - 1);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_reg;
  logic [N-1:0]    gnt_reg;
  logic [PW-1:0]   g_reg;
  logic [PW-1:0]   rr_ptr_reg;
  logic [TW-1:0]   tmo_cnt_reg;
  logic            abort_reg;

  logic            pick_valid;
  logic [PW-1:0]   pick_idx;
  logic [PW-1:0]   scan_idx;
  logic [PW-1:0]   next_ptr;
  logic            xfer;

  // Scan from rr_ptr upward with explicit wrap so N need not be a power of 2.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    scan_idx   = rr_ptr_reg;
    for (int j = 0; j < N; j++) begin
      if (!pick_valid && req[scan_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = scan_idx;
      end
      scan_idx = (scan_idx == LAST_IDX) ? '0 : scan_idx + 1'b1;
    end
  end

  assign next_ptr    = (g_reg == LAST_IDX) ? '0 : g_reg + 1'b1;
  assign busy        = (state_reg == GRANT);
  assign xfer        = busy & req[g_reg] & ~fifo_full;
  assign fifo_wr     = xfer;
  assign fifo_w_data = data[g_reg*B +: B];
  assign gnt         = gnt_reg;
  assign abort       = abort_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_ack
      assign ack[gi] = gnt_reg[gi] & xfer;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      gnt_reg     <= '0;
      g_reg       <= '0;
      rr_ptr_reg  <= '0;
      tmo_cnt_reg <= '0;
      abort_reg   <= 1'b0;
    end else begin
      abort_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            state_reg   <= GRANT;
            gnt_reg     <= {{(N-1){1'b0}}, 1'b1} << pick_idx;
            g_reg       <= pick_idx;
            tmo_cnt_reg <= '0;
          end
        end
        GRANT: begin
          if (xfer && last[g_reg]) begin
            state_reg  <= IDLE;
            gnt_reg    <= '0;
            rr_ptr_reg <= next_ptr;
          end else if (req[g_reg]) begin
            // A full FIFO with req held is a stall, not an idle requester.
            tmo_cnt_reg <= '0;
          end else if (tmo_cnt_reg == TMO_LIMIT) begin
            state_reg   <= IDLE;
            gnt_reg     <= '0;
            rr_ptr_reg  <= next_ptr;
            tmo_cnt_reg <= '0;
            abort_reg   <= 1'b1;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          gnt_reg   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: an N=2 instance for packet/stall/timeout/reset
// scenarios and an N=3 instance for rotation order, checked every cycle.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst2, full2, wr2, busy2, abort2;
  logic [1:0]  req2, last2, ack2, gnt2;
  logic [15:0] data2;
  logic [7:0]  wd2;

  logic        rst3, full3, wr3, busy3, abort3;
  logic [2:0]  req3, last3, ack3, gnt3;
  logic [23:0] data3;
  logic [7:0]  wd3;

  uart_tx_arbiter #(.N(2), .B(8), .TIMEOUT(16)) dut2 (
    .clk(clk), .rst(rst2), .req(req2), .data(data2), .last(last2),
    .ack(ack2), .gnt(gnt2), .fifo_full(full2), .fifo_wr(wr2),
    .fifo_w_data(wd2), .busy(busy2), .abort(abort2)
  );

  uart_tx_arbiter #(.N(3), .B(8), .TIMEOUT(4)) dut3 (
    .clk(clk), .rst(rst3), .req(req3), .data(data3), .last(last3),
    .ack(ack3), .gnt(gnt3), .fifo_full(full3), .fifo_wr(wr3),
    .fifo_w_data(wd3), .busy(busy3), .abort(abort3)
  );

  int tests_run = 0;
  int tests_failed = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Requester byte queues: 0,1 feed the N=2 instance, 2..4 feed the N=3 instance.
  logic [7:0] qb [5][16];
  bit         ql [5][16];
  int         head [5];
  int         tail [5];
  bit         hold [5];
  bit         acked [5];

  task automatic push(int r, logic [7:0] b, bit l);
    qb[r][tail[r]] = b;
    ql[r][tail[r]] = l;
    tail[r]++;
  endtask

  task automatic clear_q(int r);
    head[r] = 0;
    tail[r] = 0;
    hold[r] = 1'b0;
  endtask

  task automatic drive();
    bit has;
    logic [7:0] d;
    bit l;
    for (int r = 0; r < 5; r++) begin
      has = (head[r] < tail[r]) && !hold[r];
      d   = has ? qb[r][head[r]] : 8'h00;
      l   = has ? ql[r][head[r]] : 1'b0;
      if (r < 2) begin
        req2[r] = has; data2[r*8 +: 8] = d; last2[r] = l;
      end else begin
        req3[r-2] = has; data3[(r-2)*8 +: 8] = d; last3[r-2] = l;
      end
    end
  endtask

  task automatic cycle();
    drive();
    @(negedge clk);
    for (int r = 0; r < 5; r++) acked[r] = (r < 2) ? ack2[r] : ack3[r-2];
    @(posedge clk);
    #1;
    for (int r = 0; r < 5; r++) if (acked[r]) head[r]++;
  endtask

  // Behavioural model: granted index (-1 = idle), rotation start, req-low run length.
  int m_g   [2] = '{-1, -1};
  int m_ptr [2] = '{0, 0};
  int m_low [2] = '{0, 0};
  bit m_abort [2] = '{1'b0, 1'b0};
  bit chk_en = 1'b0;

  task automatic model_step(int k, int n, int tmo, logic r, logic [2:0] rq,
                            logic [2:0] ls, logic fl, logic [23:0] dt,
                            logic [2:0] g, logic [2:0] a, logic w,
                            logic [7:0] wd, logic b, logic ab);
    bit xfer;
    int idx;
    xfer = (m_g[k] >= 0) && rq[m_g[k]] && !fl;
    if (chk_en) begin
      chk($sformatf("dut%0d gnt", k), 32'(g), (m_g[k] >= 0) ? (32'd1 << m_g[k]) : 32'd0);
      chk($sformatf("dut%0d busy", k), 32'(b), 32'(m_g[k] >= 0));
      chk($sformatf("dut%0d abort", k), 32'(ab), 32'(m_abort[k]));
      chk($sformatf("dut%0d fifo_wr", k), 32'(w), 32'(xfer));
      chk($sformatf("dut%0d ack", k), 32'(a), xfer ? (32'd1 << m_g[k]) : 32'd0);
      if (m_g[k] >= 0) chk($sformatf("dut%0d w_data", k), 32'(wd), 32'(dt[m_g[k]*8 +: 8]));
    end
    if (r) begin
      m_g[k] = -1; m_ptr[k] = 0; m_low[k] = 0; m_abort[k] = 1'b0;
    end else begin
      m_abort[k] = 1'b0;
      if (m_g[k] < 0) begin
        for (int j = n - 1; j >= 0; j--) begin
          idx = (m_ptr[k] + j) % n;
          if (rq[idx]) m_g[k] = idx;
        end
        m_low[k] = 0;
      end else if (xfer && ls[m_g[k]]) begin
        m_ptr[k] = (m_g[k] + 1) % n;
        m_g[k]   = -1;
      end else if (rq[m_g[k]]) begin
        m_low[k] = 0;
      end else begin
        m_low[k]++;
        if (m_low[k] == tmo) begin
          m_abort[k] = 1'b1;
          m_ptr[k]   = (m_g[k] + 1) % n;
          m_g[k]     = -1;
          m_low[k]   = 0;
        end
      end
    end
  endtask

  logic [7:0] cap2 [$];
  logic [7:0] cap3 [$];
  int         order3 [$];
  int         abort_cnt = 0;
  logic [2:0] prev_gnt3 = 3'b000;

  always @(negedge clk) begin
    model_step(0, 2, 16, rst2, {1'b0, req2}, {1'b0, last2}, full2, {8'h00, data2},
               {1'b0, gnt2}, {1'b0, ack2}, wr2, wd2, busy2, abort2);
    model_step(1, 3, 4, rst3, req3, last3, full3, data3, gnt3, ack3, wr3, wd3, busy3, abort3);
    if (chk_en && wr2) begin
      cap2.push_back(wd2);
      $display("[TB] dut0 write 0x%02h gnt=%b at %0t", wd2, gnt2, $time);
    end
    if (chk_en && wr3) begin
      cap3.push_back(wd3);
      $display("[TB] dut1 write 0x%02h gnt=%b at %0t", wd3, gnt3, $time);
    end
    if (chk_en && abort2) abort_cnt++;
    if (chk_en && gnt3 != 3'b000 && prev_gnt3 == 3'b000)
      order3.push_back(gnt3[0] ? 0 : (gnt3[1] ? 1 : 2));
    prev_gnt3 = gnt3;
  end

  function automatic logic [31:0] pack(input logic [7:0] q [$]);
    logic [31:0] v = 32'd0;
    foreach (q[i]) v = (v << 8) | 32'(q[i]);
    return v;
  endfunction

  int exp_order [5] = '{0, 1, 2, 0, 1};

  initial begin
    rst2 = 1'b1; rst3 = 1'b1; full2 = 1'b0; full3 = 1'b0;
    req2 = '0; last2 = '0; data2 = '0; req3 = '0; last3 = '0; data3 = '0;
    for (int r = 0; r < 5; r++) begin clear_q(r); acked[r] = 1'b0; end
    cycle(); cycle();
    rst2 = 1'b0; rst3 = 1'b0; chk_en = 1'b1;

    // Single 3-byte packet from requester 0.
    push(0, 8'h41, 0); push(0, 8'h42, 0); push(0, 8'h43, 1);
    cycle();
    chk("t1 gnt after req", 32'(gnt2), 32'h1);
    repeat (3) cycle();
    chk("t1 gnt released", 32'(gnt2), 32'h0);
    chk("t1 byte count", 32'(cap2.size()), 32'd3);
    chk("t1 bytes", pack(cap2), 32'h00414243);

    // rr_ptr moved to 1: simultaneous requests go to requester 1 first.
    cap2.delete();
    push(0, 8'h51, 1); push(1, 8'h61, 1);
    cycle();
    chk("t1 rr_ptr=1 gnt", 32'(gnt2), 32'h2);
    repeat (3) cycle();
    chk("t1 rr order", pack(cap2), 32'h00006151);

    // Both request right after reset, 2-byte packets.
    rst2 = 1'b1; clear_q(0); clear_q(1);
    cycle();
    rst2 = 1'b0; cap2.delete();
    push(0, 8'hA0, 0); push(0, 8'hA1, 1); push(1, 8'hB0, 0); push(1, 8'hB1, 1);
    repeat (8) cycle();
    chk("t2 no interleave", pack(cap2), 32'hA0A1B0B1);

    // FIFO full for 5 cycles mid-packet.
    cap2.delete();
    push(0, 8'hC0, 0); push(0, 8'hC1, 0); push(0, 8'hC2, 1);
    cycle(); cycle();
    full2 = 1'b1;
    repeat (5) cycle();
    chk("t3 no write while full", 32'(cap2.size()), 32'd1);
    full2 = 1'b0;
    repeat (3) cycle();
    chk("t3 resumed bytes", pack(cap2), 32'h00C0C1C2);
    chk("t3 no abort", 32'(abort_cnt), 32'd0);

    // Requester 1 stalls mid-packet; requester 0 waits.
    cap2.delete();
    push(1, 8'hD0, 0); push(1, 8'hD1, 0); push(1, 8'hD2, 1);
    cycle(); cycle();
    hold[1] = 1'b1;
    push(0, 8'hE0, 1);
    repeat (15) cycle();
    chk("t4 no early abort", 32'(abort2), 32'd0);
    chk("t4 still granted", 32'(gnt2), 32'h2);
    cycle();
    chk("t4 abort pulse", 32'(abort2), 32'd1);
    chk("t4 gnt dropped", 32'(gnt2), 32'h0);
    cycle();
    chk("t4 pending req0 granted", 32'(gnt2), 32'h1);
    chk("t4 abort one cycle", 32'(abort2), 32'd0);
    cycle();
    chk("t4 fifo contents", pack(cap2), 32'h0000D0E0);
    clear_q(1);

    // Reset in the middle of a packet.
    cap2.delete();
    push(0, 8'hF0, 0); push(0, 8'hF1, 0); push(0, 8'hF2, 1);
    cycle(); cycle();
    rst2 = 1'b1;
    cycle();
    chk("t5 gnt after rst", 32'(gnt2), 32'h0);
    chk("t5 busy after rst", 32'(busy2), 32'd0);
    chk("t5 fifo_wr after rst", 32'(wr2), 32'd0);
    rst2 = 1'b0; clear_q(0); clear_q(1);
    push(0, 8'h30, 1); push(1, 8'h31, 1);
    cycle();
    chk("t5 rr_ptr reset", 32'(gnt2), 32'h1);
    repeat (4) cycle();
    chk("t5 fifo contents", pack(cap2), 32'hF0F13031);

    // N=3 rotation with 1-byte packets held on all requesters.
    push(2, 8'h10, 1); push(2, 8'h11, 1);
    push(3, 8'h20, 1); push(3, 8'h21, 1);
    push(4, 8'h30, 1); push(4, 8'h31, 1);
    repeat (14) cycle();
    chk("t6 grant count", 32'(order3.size()), 32'd6);
    for (int i = 0; i < 5; i++)
      if (i < order3.size()) chk($sformatf("t6 grant %0d", i), 32'(order3[i]), 32'(exp_order[i]));
    chk("t6 byte count", 32'(cap3.size()), 32'd6);
    chk("t6 bytes", pack(cap3), 32'h30112131);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
